uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_tx_fifo_drain.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a first-word-fall-through TX FIFO and shifts each
// word out as start, DBIT data bits LSB first, optional parity, then stop.
module uart_tx_fifo_drain #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int              NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [5:0]      SB_LAST = 6'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST  = NW'(DBIT - 1);
  localparam logic            ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [5:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    par_d        = par_q;
    tx_d         = tx_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // The pop is masked while reset is held so a discarded frame never costs a word.
        fifo_rd = ~fifo_empty & ~rst;
        if (!fifo_empty) begin
          b_d     = fifo_r_data;
          par_d   = (^fifo_r_data) ^ ODD;
          s_d     = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == 6'd15) begin
            s_d     = '0;
            n_d     = '0;
            tx_d    = b_q[0];
            state_d = DATA;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == 6'd15) begin
            s_d  = '0;
            b_d  = b_q >> 1;
            tx_d = b_q[1];
            if (n_q == N_LAST) begin
              if (PARITY_EN != 0) begin
                tx_d    = par_q;
                state_d = PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = STOP;
              end
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_q == 6'd15) begin
            s_d     = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            s_d          = '0;
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four instances (plain, even parity, odd parity,
// 2 stop bits with tick tied high) checked every cycle against a tick-count line model.
module tb_uart_tx_fifo_drain;

  localparam logic [3:0] PEN_V  = 4'b0110;
  localparam logic [3:0] PODD_V = 4'b0100;

  logic       clk = 1'b0;
  logic [3:0] rst, s_tick, fifo_empty, fifo_rd, tx, tx_busy, tx_done;
  logic [7:0] fifo_data [4];

  logic [7:0] mem [4][64];
  logic [5:0] wr_ptr [4];
  logic [5:0] rd_ptr [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_mode [4];

  logic       m_act   [4];
  int         m_k     [4];
  logic [7:0] m_word  [4];
  int         samp_pos[4];
  logic [15:0] cap    [4];
  int n_push [4], n_pops [4], n_done [4], n_mframes [4];
  int last_pop [4], last_done [4], fr_ticks [4], meas_ticks [4], meas_clks [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    assign fifo_empty[gi] = (wr_ptr[gi] == rd_ptr[gi]);
    assign fifo_data[gi]  = mem[gi][rd_ptr[gi]];
    uart_tx_fifo_drain #(
      .DBIT(8), .SB_TICK((gi == 3) ? 32 : 16),
      .PARITY_EN(int'(PEN_V[gi])), .PARITY_ODD(int'(PODD_V[gi]))
    ) u_dut (
      .clk(clk), .rst(rst[gi]), .s_tick(s_tick[gi]), .fifo_empty(fifo_empty[gi]),
      .fifo_r_data(fifo_data[gi]), .fifo_rd(fifo_rd[gi]), .tx(tx[gi]),
      .tx_busy(tx_busy[gi]), .tx_done_tick(tx_done[gi])
    );
  end

  // Frame as a list of 16-tick line positions followed by the stop period.
  function automatic int nb_of(int i);
    return 9 + int'(PEN_V[2'(i)]);
  endfunction
  function automatic int total_of(int i);
    return 16 * nb_of(i) + ((i == 3) ? 32 : 16);
  endfunction
  function automatic logic line_bit(int i, logic [7:0] w, int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return w[3'(pos - 1)];
    if (pos == 9 && PEN_V[2'(i)]) return (^w) ^ PODD_V[2'(i)];
    return 1'b1;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wr_ptr[i]] = d;
    wr_ptr[i] = wr_ptr[i] + 6'd1;
    n_push[i]++;
  endtask

  task automatic cycle();
    logic [3:0] pop;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      case (tick_mode[i])
        0:       s_tick[i] = (cyc % 4 == 0);
        1:       s_tick[i] = 1'b1;
        default: s_tick[i] = ($urandom_range(0, 2) == 0);
      endcase
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      logic live;
      logic [3:0] want, got;
      live    = m_act[i] && !rst[i];
      want[3] = !m_act[i] && !rst[i] && !fifo_empty[i];
      want[2] = live;
      want[1] = live && s_tick[i] && (m_k[i] + 1 == total_of(i));
      want[0] = !live ? 1'b1 :
                (m_k[i] < 16 * nb_of(i)) ? line_bit(i, m_word[i], m_k[i] / 16) : 1'b1;
      got = {fifo_rd[i], tx_busy[i], tx_done[i], tx[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle cyc%0d inst%0d {rd,busy,done,tx}: got %b want %b", cyc, i, got, want);
      end
      if (samp_pos[i] >= 0) cap[i][4'(samp_pos[i])] = tx[i];
      pop[i] = fifo_rd[i];
      if (fifo_rd[i]) begin
        n_pops[i]++;
        last_pop[i] = cyc;
        fr_ticks[i] = 0;
      end else if (s_tick[i] && tx_busy[i]) begin
        fr_ticks[i]++;
      end
      if (tx_done[i]) begin
        n_done[i]++;
        last_done[i]  = cyc;
        meas_ticks[i] = fr_ticks[i];
        meas_clks[i]  = cyc - last_pop[i];
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      samp_pos[i] = -1;
      if (pop[i]) rd_ptr[i] = rd_ptr[i] + 6'd1;
      if (rst[i]) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (!fifo_empty[i] || pop[i]) begin
          m_act[i]  = 1'b1;
          m_k[i]    = 0;
          m_word[i] = mem[i][rd_ptr[i] - (pop[i] ? 6'd1 : 6'd0)];
          cap[i]    = '0;
        end
      end else if (s_tick[i]) begin
        m_k[i]++;
        if (m_k[i] >= total_of(i)) begin
          m_act[i] = 1'b0;
          n_mframes[i]++;
        end else if (m_k[i] % 16 == 8) begin
          samp_pos[i] = m_k[i] / 16;
        end
      end
    end
    cyc++;
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (n_done[i] < target && n < budget) begin
      cycle();
      n++;
    end
    check($sformatf("done_timeout inst%0d", i), n_done[i], target);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [15:0] line;
    int         nbits;
    int         ticks;
    int         clks;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [3:0] idle_bad;
    int p0, d0, d1, n;
    vecs[0] = '{inst: 0, data: 8'hA5, line: 16'h034A, nbits: 10, ticks: 160, clks: 0};
    vecs[1] = '{inst: 0, data: 8'h00, line: 16'h0200, nbits: 10, ticks: 160, clks: 0};
    vecs[2] = '{inst: 1, data: 8'h07, line: 16'h060E, nbits: 11, ticks: 176, clks: 0};
    vecs[3] = '{inst: 2, data: 8'h07, line: 16'h040E, nbits: 11, ticks: 176, clks: 0};
    vecs[4] = '{inst: 1, data: 8'hFF, line: 16'h05FE, nbits: 11, ticks: 176, clks: 0};
    vecs[5] = '{inst: 3, data: 8'hA5, line: 16'h034A, nbits: 10, ticks: 176, clks: 176};
    vecs[6] = '{inst: 3, data: 8'hFF, line: 16'h03FE, nbits: 10, ticks: 176, clks: 176};
    vecs[7] = '{inst: 2, data: 8'h80, line: 16'h0500, nbits: 11, ticks: 176, clks: 0};

    rst = 4'hF;
    s_tick = '0;
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = '0; rd_ptr[i] = '0; m_act[i] = 1'b0; m_k[i] = 0; m_word[i] = '0;
      samp_pos[i] = -1; cap[i] = '0; n_push[i] = 0; n_pops[i] = 0; n_done[i] = 0;
      n_mframes[i] = 0; last_pop[i] = 0; last_done[i] = 0; fr_ticks[i] = 0;
      meas_ticks[i] = 0; meas_clks[i] = 0;
      tick_mode[i] = (i == 3) ? 1 : 0;
    end

    repeat (3) cycle();
    check("reset_tx", int'(tx), 4'hF);
    check("reset_busy", int'(tx_busy), 0);
    rst = 4'h0;
    repeat (4) cycle();

    for (int v = 0; v < 8; v++) begin
      int i;
      logic [15:0] mask;
      i = vecs[v].inst;
      mask = 16'((32'd1 << vecs[v].nbits) - 1);
      push(i, vecs[v].data);
      wait_done(i, n_done[i] + 1, 4000);
      check($sformatf("vec%0d line", v), int'(cap[i] & mask), int'(vecs[v].line));
      check($sformatf("vec%0d ticks", v), meas_ticks[i], vecs[v].ticks);
      if (vecs[v].clks != 0) check($sformatf("vec%0d clks", v), meas_clks[i], vecs[v].clks);
      $display("vec %0d inst %0d data %02h line %03h ticks %0d clks %0d",
               v, i, vecs[v].data, cap[i] & mask, meas_ticks[i], meas_clks[i]);
      repeat (2) cycle();
    end

    // Back-to-back: second pop must follow the first done pulse by one clk.
    p0 = n_pops[0];
    d0 = n_done[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_done(0, d0 + 1, 4000);
    d1 = last_done[0];
    wait_done(0, d0 + 2, 4000);
    check("b2b_gap", last_pop[0] - d1, 1);
    check("b2b_pops", n_pops[0] - p0, 2);
    check("b2b_line", int'(cap[0] & 16'h03FF), 16'h03FE);
    $display("b2b inst 0 done1 cyc %0d pop2 cyc %0d", d1, last_pop[0]);

    // Empty FIFO with ticks running: nothing may move.
    for (int i = 0; i < 3; i++) tick_mode[i] = 2;
    idle_bad = '0;
    repeat (1000) begin
      cycle();
      idle_bad = idle_bad | fifo_rd | tx_busy | ~tx;
    end
    check("empty_idle", int'(idle_bad), 0);
    $display("empty 1000 clk idle flags %b", idle_bad);

    // Reset during data bit 3 of 0x3C, then 0x5A must go out intact.
    tick_mode[0] = 0;
    p0 = n_pops[0];
    push(0, 8'h3C);
    push(0, 8'h5A);
    n = 0;
    while (!(m_act[0] && m_k[0] >= 16 * 4 + 4) && n < 4000) begin
      cycle();
      n++;
    end
    check("rst_reach_bit3", int'(m_act[0] && m_k[0] >= 68), 1);
    d0 = n_done[0];
    rst[0] = 1'b1;
    #1;
    check("rst_tx_now", int'(tx[0]), 1);
    check("rst_busy_now", int'(tx_busy[0]), 0);
    repeat (3) cycle();
    check("rst_no_done", n_done[0] - d0, 0);
    rst[0] = 1'b0;
    wait_done(0, d0 + 1, 4000);
    check("rst_next_line", int'(cap[0] & 16'h03FF), 16'h02B4);
    check("rst_pops", n_pops[0] - p0, 2);
    $display("reset inst 0 next frame line %03h", cap[0] & 16'h03FF);

    // Random traffic and tick phases on every instance.
    for (int i = 0; i < 3; i++) tick_mode[i] = 2;
    repeat (5000) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 399) == 0 && 6'(wr_ptr[i] - rd_ptr[i]) < 6'd50)
          push(i, 8'($urandom));
      cycle();
    end
    n = 0;
    while (n < 30000 && (fifo_empty != 4'hF || m_act[0] || m_act[1] || m_act[2] || m_act[3])) begin
      cycle();
      n++;
    end
    check("drain_timeout", int'(n < 30000), 1);
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pops inst%0d", i), n_pops[i], n_push[i]);
      check($sformatf("dones inst%0d", i), n_done[i], n_mframes[i]);
      $display("random inst %0d pushed %0d popped %0d frames %0d", i, n_push[i], n_pops[i], n_done[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
